// File: rtl/sc_backg_pkg.sv
// Shared types for the background-transition block: FSM states, pattern mode codes
// and default sizing.
package sc_backg_pkg;

    localparam int DEFAULT_DATAWIDTH  = 8;
    localparam int DEFAULT_STEP_TICKS = 25000000;
    localparam int DEFAULT_NUM_STEPS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } backg_state_e;

    typedef enum logic [1:0] {
        FILL_L  = 2'b00,
        FILL_R  = 2'b01,
        BLINK   = 2'b10,
        ERASE_L = 2'b11
    } backg_mode_e;

endpackage

// File: rtl/sc_step_prescaler.sv
// Down-counting step prescaler: loaded while a strobe is emitted, counts down while
// waiting, and flags terminal count when it reaches zero.
module sc_step_prescaler #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_count,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/sc_backg_transition.sv
// Background transition sequencer: emits NUM_STEPS row patterns, one strobe every
// STEP_TICKS cycles, in one of four fill/blink/erase modes.
module sc_backg_transition
    import sc_backg_pkg::*;
#(
    parameter int BACKGTRANSITION_DATAWIDTH  = DEFAULT_DATAWIDTH,
    parameter int BACKGTRANSITION_STEP_TICKS = DEFAULT_STEP_TICKS,
    parameter int BACKGTRANSITION_NUM_STEPS  = DEFAULT_NUM_STEPS
) (
    input  logic                                 SC_BACKGTRANSITION_CLOCK_50,
    input  logic                                 SC_BACKGTRANSITION_RESET_InHigh,
    input  logic                                 SC_BACKGTRANSITION_start_InLow,
    input  logic                                 SC_BACKGTRANSITION_abort_InLow,
    input  logic [1:0]                           SC_BACKGTRANSITION_mode_In,
    output logic                                 SC_BACKGTRANSITION_transition_Out,
    output logic [BACKGTRANSITION_DATAWIDTH-1:0] SC_BACKGTRANSITION_transitionDATA_OutBUS,
    output logic                                 SC_BACKGTRANSITION_busy_Out,
    output logic                                 SC_BACKGTRANSITION_done_Out
);

    localparam int W      = BACKGTRANSITION_DATAWIDTH;
    localparam int STEP_W = (BACKGTRANSITION_NUM_STEPS > 1) ? $clog2(BACKGTRANSITION_NUM_STEPS) : 1;
    localparam int CNT_W  = (BACKGTRANSITION_STEP_TICKS > 2) ? $clog2(BACKGTRANSITION_STEP_TICKS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(BACKGTRANSITION_NUM_STEPS - 1);
    localparam logic [CNT_W-1:0]  LOAD_VALUE = CNT_W'(BACKGTRANSITION_STEP_TICKS - 2);
    localparam logic [W-1:0]      ONES       = '1;

    backg_state_e      r_state, w_nextState;
    backg_mode_e       r_mode, w_nextMode;
    logic [STEP_W-1:0] r_step, w_nextStep;
    logic [W-1:0]      r_data, w_pattern;
    logic              w_loadData;
    logic              w_tc;

    // Loaded in EMIT so the WAIT that follows lasts STEP_TICKS-1 cycles.
    sc_step_prescaler #(
        .WIDTH(CNT_W)
    ) u_prescaler (
        .clk        (SC_BACKGTRANSITION_CLOCK_50),
        .rst        (SC_BACKGTRANSITION_RESET_InHigh),
        .i_load     (r_state == ST_EMIT),
        .i_count    (r_state == ST_WAIT),
        .i_loadValue(LOAD_VALUE),
        .o_tc       (w_tc)
    );

    always_ff @(posedge SC_BACKGTRANSITION_CLOCK_50 or posedge SC_BACKGTRANSITION_RESET_InHigh) begin
        if (SC_BACKGTRANSITION_RESET_InHigh) begin
            r_state <= ST_IDLE;
            r_mode  <= FILL_L;
            r_step  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_nextState;
            r_mode  <= w_nextMode;
            r_step  <= w_nextStep;
            if (w_loadData) begin
                r_data <= w_pattern;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextMode  = r_mode;
        w_nextStep  = r_step;
        w_loadData  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!SC_BACKGTRANSITION_start_InLow && SC_BACKGTRANSITION_abort_InLow) begin
                    w_nextState = ST_EMIT;
                    w_nextMode  = backg_mode_e'(SC_BACKGTRANSITION_mode_In);
                    w_nextStep  = '0;
                    w_loadData  = 1'b1;
                end
            end
            ST_EMIT: begin
                w_nextState = SC_BACKGTRANSITION_abort_InLow ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!SC_BACKGTRANSITION_abort_InLow) begin
                    w_nextState = ST_IDLE;
                end else if (w_tc) begin
                    if (r_step == LAST_STEP) begin
                        w_nextState = ST_DONE;
                    end else begin
                        w_nextState = ST_EMIT;
                        w_nextStep  = r_step + STEP_W'(1);
                        w_loadData  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Pattern is computed from the values the step/mode registers are about to take.
    always_comb begin
        w_pattern = '0;
        case (w_nextMode)
            FILL_L:  w_pattern = ~(ONES >> (int'(w_nextStep) + 1));
            FILL_R:  w_pattern = ~(ONES << (int'(w_nextStep) + 1));
            BLINK:   w_pattern = w_nextStep[0] ? '0 : ONES;
            ERASE_L: w_pattern = ONES >> (int'(w_nextStep) + 1);
            default: w_pattern = '0;
        endcase
    end

    assign SC_BACKGTRANSITION_transition_Out        = (r_state == ST_EMIT);
    assign SC_BACKGTRANSITION_busy_Out              = (r_state != ST_IDLE);
    assign SC_BACKGTRANSITION_done_Out              = (r_state == ST_DONE);
    assign SC_BACKGTRANSITION_transitionDATA_OutBUS = r_data;

endmodule

// File: tb/tb_sc_backg_transition.sv
// Directed bench for sc_backg_transition with STEP_TICKS=4: one table-driven run per
// mode, then abort, collision and mid-transition reset sequences.
module tb_sc_backg_transition;

    localparam int W  = 8;
    localparam int T  = 4;
    localparam int NS = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         startN;
    logic         abortN;
    logic [1:0]   mode;
    logic         strobe;
    logic [W-1:0] data;
    logic         busy;
    logic         done;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct packed {
        logic [1:0]             mode;
        logic [NS-1:0][W-1:0]   patt;
    } vec_t;

    vec_t vecs [4];

    sc_backg_transition #(
        .BACKGTRANSITION_DATAWIDTH (W),
        .BACKGTRANSITION_STEP_TICKS(T),
        .BACKGTRANSITION_NUM_STEPS (NS)
    ) dut (
        .SC_BACKGTRANSITION_CLOCK_50            (clock),
        .SC_BACKGTRANSITION_RESET_InHigh        (reset),
        .SC_BACKGTRANSITION_start_InLow         (startN),
        .SC_BACKGTRANSITION_abort_InLow         (abortN),
        .SC_BACKGTRANSITION_mode_In             (mode),
        .SC_BACKGTRANSITION_transition_Out      (strobe),
        .SC_BACKGTRANSITION_transitionDATA_OutBUS(data),
        .SC_BACKGTRANSITION_busy_Out            (busy),
        .SC_BACKGTRANSITION_done_Out            (done)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic s, input logic a, input logic [1:0] m);
        startN = s;
        abortN = a;
        mode   = m;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Full transition; cycle c counts negedges after the edge that accepted start.
    task automatic runVector(input vec_t v, input bit holdStart);
        int strobes;
        int k;
        strobes = 0;
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, v.mode);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clock);
            k = (c - 1) / 4;
            if (k > NS - 1) k = NS - 1;
            if (strobe) strobes++;
            checkOutput($sformatf("strobe m%0d c%0d", v.mode, c), {31'd0, strobe},
                        {31'd0, (c <= 29) && (((c - 1) % 4) == 0)});
            checkOutput($sformatf("busy m%0d c%0d", v.mode, c), {31'd0, busy}, {31'd0, c <= 33});
            checkOutput($sformatf("done m%0d c%0d", v.mode, c), {31'd0, done}, {31'd0, c == 33});
            checkOutput($sformatf("data m%0d c%0d", v.mode, c), {24'd0, data}, {24'd0, v.patt[k]});
            if (c == 1 && !holdStart) applyStimulus(1'b1, 1'b1, ~v.mode);
            if (c == 1 && holdStart)  applyStimulus(1'b0, 1'b1, ~v.mode);
            if (c == 33)              applyStimulus(1'b1, 1'b1, v.mode);
        end
        checkOutput($sformatf("strobe count m%0d", v.mode), strobes, 32'd8);
    endtask

    initial begin
        vecs[0] = '{mode: 2'b00, patt: {8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80}};
        vecs[1] = '{mode: 2'b01, patt: {8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01}};
        vecs[2] = '{mode: 2'b10, patt: {8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF}};
        vecs[3] = '{mode: 2'b11, patt: {8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F}};

        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'b00);
        repeat (3) @(negedge clock);
        checkOutput("reset strobe", {31'd0, strobe}, 32'd0);
        checkOutput("reset busy",   {31'd0, busy},   32'd0);
        checkOutput("reset done",   {31'd0, done},   32'd0);
        checkOutput("reset data",   {24'd0, data},   32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            runVector(vecs[i], 1'b0);
        end

        // Start held low through the whole transition is ignored while busy.
        runVector(vecs[1], 1'b1);

        // Abort during the WAIT after the third strobe.
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 2'b00);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 1) applyStimulus(1'b1, 1'b1, 2'b00);
            if (c == 10) applyStimulus(1'b1, 1'b0, 2'b00);
        end
        checkOutput("abort strobe seen", {31'd0, busy}, 32'd1);
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 2'b00);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("abort busy %0d", c),   {31'd0, busy},   32'd0);
            checkOutput($sformatf("abort done %0d", c),   {31'd0, done},   32'd0);
            checkOutput($sformatf("abort strobe %0d", c), {31'd0, strobe}, 32'd0);
            checkOutput($sformatf("abort data %0d", c),   {24'd0, data},   32'h0000_00E0);
            @(negedge clock);
        end

        // Start and abort together in IDLE: abort wins.
        applyStimulus(1'b0, 1'b0, 2'b01);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checkOutput($sformatf("collide busy %0d", c),   {31'd0, busy},   32'd0);
            checkOutput($sformatf("collide strobe %0d", c), {31'd0, strobe}, 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 2'b01);

        // Reset asserted asynchronously mid-WAIT.
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 2'b01);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c == 1) applyStimulus(1'b1, 1'b1, 2'b01);
        end
        checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
        checkOutput("pre-reset data", {24'd0, data}, 32'h0000_0003);
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset busy",   {31'd0, busy},   32'd0);
        checkOutput("async reset strobe", {31'd0, strobe}, 32'd0);
        checkOutput("async reset done",   {31'd0, done},   32'd0);
        checkOutput("async reset data",   {24'd0, data},   32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("post-reset strobe %0d", c), {31'd0, strobe}, 32'd0);
            checkOutput($sformatf("post-reset busy %0d", c),   {31'd0, busy},   32'd0);
        end
        runVector(vecs[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sc_backg_transition.md
SC_BACKG_TRANSITION -- requirements
Module: sc_backg_transition

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; parameters and ports SHALL be as listed below.
REQ-002 Parameter BACKGTRANSITION_DATAWIDTH, default 8: width of the emitted row pattern.
REQ-003 Parameter BACKGTRANSITION_STEP_TICKS, default 25000000: clock cycles between successive pattern steps; minimum 2.
REQ-004 Parameter BACKGTRANSITION_NUM_STEPS, default 8: steps per transition, equal to DATAWIDTH.
REQ-005 SC_BACKGTRANSITION_CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-006 SC_BACKGTRANSITION_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-007 SC_BACKGTRANSITION_start_InLow  in  1  start request, active low, sampled each rising edge.
REQ-008 SC_BACKGTRANSITION_abort_InLow  in  1  abort, active low, sampled each rising edge.
REQ-009 SC_BACKGTRANSITION_mode_In  in  2  pattern mode, captured only on an accepted start.
REQ-010 SC_BACKGTRANSITION_transition_Out  out  1  one-cycle strobe: data bus valid, downstream register loads it.
REQ-011 SC_BACKGTRANSITION_transitionDATA_OutBUS  out  DATAWIDTH  registered row pattern.
REQ-012 SC_BACKGTRANSITION_busy_Out  out  1  high while a transition is in progress.
REQ-013 SC_BACKGTRANSITION_done_Out  out  1  one-cycle pulse on normal completion.

Function
REQ-014 The FSM SHALL have four states: IDLE, EMIT, WAIT and DONE.
REQ-015 IDLE: start_InLow=0 and abort_InLow=1 at edge N SHALL capture mode, set step=0 and enter EMIT at N+1.
REQ-016 EMIT: the block SHALL drive transition_Out=1 for exactly one cycle with the step-k pattern on the data bus, then enter WAIT.
REQ-017 WAIT: the block SHALL count STEP_TICKS-1 cycles; then if step<NUM_STEPS-1 it SHALL increment step and enter EMIT, else enter DONE.
REQ-018 Strobe spacing SHALL therefore be exactly STEP_TICKS cycles.
REQ-019 DONE: the block SHALL assert done_Out for one cycle and return to IDLE.
REQ-020 busy_Out SHALL be high in EMIT, WAIT and DONE, and low in IDLE.
REQ-021 Pattern for step k (0..NUM_STEPS-1), mode 00, fill-left: top k+1 bits set (k=0 gives 8'h80, k=7 gives 8'hFF).
REQ-022 Pattern for mode 01, fill-right: bottom k+1 bits set (k=0 gives 8'h01, k=7 gives 8'hFF).
REQ-023 Pattern for mode 10, blink: 8'hFF for even k, 8'h00 for odd k.
REQ-024 Pattern for mode 11, erase-left: bitwise inverse of mode 00 (k=0 gives 8'h7F, k=7 gives 8'h00).
REQ-025 The data bus SHALL update only on entry to EMIT and SHALL hold its value otherwise.
REQ-026 A start asserted while busy SHALL be ignored; mode changes while busy SHALL have no effect.
REQ-027 abort_InLow=0 in any non-IDLE state SHALL force IDLE on the next edge, with no strobe and no done; the data bus SHALL hold its value.
REQ-028 When start and abort are low in the same cycle, abort SHALL win and no transition SHALL begin.
REQ-029 start held low continuously SHALL begin one new transition per return to IDLE; no edge detection is required.

Reset
REQ-030 On reset the block SHALL enter IDLE, with step=0, tick counter=0, mode=00, data bus=0, and transition_Out, busy_Out and done_Out all 0.
REQ-031 Reset asserted mid-transition SHALL take effect immediately (asynchronously), and no further strobes SHALL occur until a new start after reset release.

Structure
REQ-032 The state encoding, mode codes (FILL_L, FILL_R, BLINK, ERASE_L) and default widths SHALL live in shared package sc_backg_pkg.
REQ-033 The tick counter SHALL be a separate sub-module, sc_step_prescaler (load/count/terminal-count output, width $clog2(STEP_TICKS)).
REQ-034 Pattern generation SHALL be combinational from (mode, step), and its result SHALL be registered into the data bus.

Verification
REQ-035 Fill-left: STEP_TICKS=4, mode=00, start at edge N -> strobes at N+1+4k, data 80,C0,E0,F0,F8,FC,FE,FF; done at N+33; busy high N+1..N+33.
REQ-036 Modes 01/10/11: same timing -> data 01,03,...,FF / FF,00,FF,00,... / 7F,3F,...,00.
REQ-037 Abort: abort_InLow=0 during the WAIT after the third strobe -> IDLE next cycle, no done, data bus holds E0.
REQ-038 Collisions: start re-asserted while busy -> ignored, exactly 8 strobes; start and abort low together in IDLE -> busy stays 0.
REQ-039 Reset mid-WAIT -> all outputs 0 immediately; no strobe until a new start after release.
